// File: rtl/vec_lsu_pkg.sv
// Shared types and lane helpers for the vector load/store unit.
// The memory port is 32 bits wide; byte lanes are selected by addr[1:0].
package vec_lsu_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_R, ST_DONE} lsu_state_e;

    typedef enum logic [1:0] {SEW8, SEW16, SEW32} sew_e;

    typedef struct packed {
        sew_e sew;
        logic illegal;
    } sew_dec_t;

    function automatic sew_dec_t width_to_sew(input logic [2:0] width);
        sew_dec_t d;
        d.illegal = 1'b0;
        case (width)
            3'b000:  d.sew = SEW8;
            3'b101:  d.sew = SEW16;
            3'b110:  d.sew = SEW32;
            default: begin
                d.sew     = SEW8;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    function automatic logic [2:0] sew_bytes(input sew_e sew);
        case (sew)
            SEW16:   return 3'd2;
            SEW32:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input sew_e sew, input logic [1:0] off);
        logic [3:0] m;
        case (sew)
            SEW16:   m = 4'b0011;
            SEW32:   m = 4'b1111;
            default: m = 4'b0001;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] lane_shift(input logic [31:0] elem, input logic [1:0] off);
        return elem << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input sew_e sew);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (sew)
            SEW8:    return {24'd0, s[7:0]};
            SEW16:   return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// Address/index generator: stride mux, address register, element counter,
// alignment check and last-element detection for vec_ldst_unit.
module vec_lsu_addr_gen
    import vec_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int VLW  = 7
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            load,
    input  logic            advance,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] stride,
    input  logic            unit_stride,
    input  sew_e            sew_in,
    input  logic [VLW-1:0]  vl,
    output sew_e            sew,
    output logic [XLEN-1:0] addr,
    output logic [VLW-1:0]  idx,
    output logic            last,
    output logic            aligned
);

    localparam logic [VLW-1:0] MAX8  = VLW'(VLEN / 8);
    localparam logic [VLW-1:0] MAX16 = VLW'(VLEN / 16);
    localparam logic [VLW-1:0] MAX32 = VLW'(VLEN / 32);

    logic [VLW-1:0]  cap;
    logic [VLW-1:0]  count_q;
    logic [XLEN-1:0] step_q;

    always_comb begin
        case (sew_in)
            SEW16:   cap = MAX16;
            SEW32:   cap = MAX32;
            default: cap = MAX8;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr    <= '0;
            idx     <= '0;
            count_q <= '0;
            step_q  <= '0;
            sew     <= SEW8;
        end else if (load) begin
            addr    <= base;
            idx     <= '0;
            count_q <= (vl < cap) ? vl : cap;
            step_q  <= unit_stride ? XLEN'(sew_bytes(sew_in)) : stride;
            sew     <= sew_in;
        end else if (advance) begin
            addr <= addr + step_q;
            idx  <= idx + 1'b1;
        end
    end

    assign last = (idx == count_q - 1'b1);

    always_comb begin
        case (sew)
            SEW16:   aligned = ~addr[0];
            SEW32:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/vec_ldst_unit.sv
// Vector load/store unit: unit/constant-stride loads and stores, SEW 8/16/32.
// Optional masking via `VEC_LSU_MASK_EN` (adds the v0_mask port).
module vec_ldst_unit
    import vec_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int VLEN  = 512,
    parameter int ELEN  = 32,
    parameter int VLMAX = VLEN / 8,
    parameter int VLW   = $clog2(VLMAX) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              ready,
    input  logic              is_store,
    input  logic              stride_sel,
    input  logic [2:0]        width,
    input  logic [VLW-1:0]    vl,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [VLEN-1:0]   vs3_data,
`ifdef VEC_LSU_MASK_EN
    input  logic [VLEN-1:0]   v0_mask,
`endif
    output logic              lsu2mem_req,
    output logic              lsu2mem_we,
    output logic [XLEN-1:0]   lsu2mem_addr,
    output logic [ELEN-1:0]   lsu2mem_wdata,
    output logic [ELEN/8-1:0] lsu2mem_be,
    input  logic              mem2lsu_gnt,
    input  logic              mem2lsu_rvalid,
    input  logic [ELEN-1:0]   mem2lsu_rdata,
    output logic [VLEN-1:0]   vd_data,
    output logic [VLEN/8-1:0] vd_be,
    output logic              done,
    output logic              err
);

    localparam int IW = $clog2(VLMAX);

    lsu_state_e      state_q, state_d;
    sew_dec_t        dec;
    sew_e            sew_q;
    logic [XLEN-1:0] addr;
    logic [VLW-1:0]  idx;
    logic            last, aligned;
    logic            load, advance, capture, fault, req;
    logic            store_q;
    logic            elem_active;
    logic [VLEN-1:0] vs3_q;
    logic [31:0]     st_elem, ld_elem;
    logic            unused_idx_msb;

    assign dec            = width_to_sew(width);
    assign unused_idx_msb = idx[VLW-1];

    vec_lsu_addr_gen #(
        .XLEN(XLEN),
        .VLEN(VLEN),
        .VLW (VLW)
    ) u_addr_gen (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (load),
        .advance    (advance),
        .base       (rs1_data),
        .stride     (rs2_data),
        .unit_stride(stride_sel),
        .sew_in     (dec.sew),
        .vl         (vl),
        .sew        (sew_q),
        .addr       (addr),
        .idx        (idx),
        .last       (last),
        .aligned    (aligned)
    );

`ifdef VEC_LSU_MASK_EN
    logic [VLMAX-1:0] mask_q;
    logic             unused_mask_hi;

    assign unused_mask_hi = ^v0_mask[VLEN-1:VLMAX];
    assign elem_active    = mask_q[idx[IW-1:0]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)    mask_q <= '0;
        else if (load) mask_q <= v0_mask[VLMAX-1:0];
    end
`else
    assign elem_active = 1'b1;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Masked-off elements are skipped before the alignment check, so they never fault.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        capture = 1'b0;
        fault   = 1'b0;
        req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (dec.illegal || vl == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (!elem_active) begin
                    advance = 1'b1;
                    state_d = last ? ST_DONE : ST_REQ;
                end else if (!aligned) begin
                    fault   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    req = 1'b1;
                    if (mem2lsu_gnt) begin
                        if (store_q) begin
                            advance = 1'b1;
                            state_d = last ? ST_DONE : ST_REQ;
                        end else begin
                            state_d = ST_WAIT_R;
                        end
                    end
                end
            end
            ST_WAIT_R: begin
                if (mem2lsu_rvalid) begin
                    capture = 1'b1;
                    advance = 1'b1;
                    state_d = last ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (sew_q)
            SEW16:   st_elem = {16'd0, vs3_q[{idx[IW-2:0], 4'b0000} +: 16]};
            SEW32:   st_elem = vs3_q[{idx[IW-3:0], 5'b00000} +: 32];
            default: st_elem = {24'd0, vs3_q[{idx[IW-1:0], 3'b000} +: 8]};
        endcase
    end

    assign ld_elem = lane_extract(mem2lsu_rdata, addr[1:0], sew_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vd_data <= '0;
            vd_be   <= '0;
            err     <= 1'b0;
            store_q <= 1'b0;
            vs3_q   <= '0;
        end else if (load) begin
            vd_data <= '0;
            vd_be   <= '0;
            err     <= dec.illegal;
            store_q <= is_store;
            vs3_q   <= vs3_data;
        end else begin
            if (fault) err <= 1'b1;
            if (capture) begin
                case (sew_q)
                    SEW16: begin
                        vd_data[{idx[IW-2:0], 4'b0000} +: 16] <= ld_elem[15:0];
                        vd_be[{idx[IW-2:0], 1'b0} +: 2]       <= 2'b11;
                    end
                    SEW32: begin
                        vd_data[{idx[IW-3:0], 5'b00000} +: 32] <= ld_elem;
                        vd_be[{idx[IW-3:0], 2'b00} +: 4]       <= 4'hF;
                    end
                    default: begin
                        vd_data[{idx[IW-1:0], 3'b000} +: 8] <= ld_elem[7:0];
                        vd_be[idx[IW-1:0]]                  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ready         = (state_q == ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign lsu2mem_req   = req;
    assign lsu2mem_we    = req & store_q;
    assign lsu2mem_addr  = req ? addr : '0;
    assign lsu2mem_be    = req ? lane_be(sew_q, addr[1:0]) : '0;
    assign lsu2mem_wdata = (req && store_q) ? lane_shift(st_elem, addr[1:0]) : '0;

endmodule
